// File: rtl/bcd_counter.sv
// bcd_counter: two-digit BCD counter with start/stop toggle, prescaler,
// synchronous clear and load, and a one-cycle carry pulse on wrap.
//
// Optional feature: define BCD_COUNTER_DOWN_EN to add the dir port
// (1 = count up, 0 = count down). The default build counts up only.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-high reset
//   start_stop  in   level; each rising edge toggles the run state
//   clr         in   synchronous clear of both digits
//   load        in   synchronous load of load_val
//   load_val    in   {tens, ones} BCD value, nibbles above 9 saturate to 9
//   dir         in   (BCD_COUNTER_DOWN_EN only) 1 = up, 0 = down
//   tens        out  BCD tens digit, 0..9
//   ones        out  BCD ones digit, 0..9
//   running     out  high while in RUNNING state
//   carry       out  one-cycle pulse on 99->00 (or 00->99 counting down)
module bcd_counter #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic       dir,
`endif
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       carry
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            start_stop_q;
  logic            ss_rise_c;
  logic            step_c;
  logic            count_up_c;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_nxt;
  logic [3:0]      tens_nxt;
  logic [3:0]      ones_nxt;
  logic            carry_nxt;

  // Clamp a loaded nibble into the legal BCD range.
  function automatic logic [3:0] sat9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

`ifdef BCD_COUNTER_DOWN_EN
  assign count_up_c = dir;
`else
  assign count_up_c = 1'b1;
`endif

  assign ss_rise_c = start_stop & ~start_stop_q;
  assign running   = (state == RUNNING);

  // State and edge-detect register; start_stop_q resets high so a level
  // held high through reset does not look like a new edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= STOPPED;
      start_stop_q <= 1'b1;
    end else begin
      state        <= state_nxt;
      start_stop_q <= start_stop;
    end
  end

  // Next state, prescaler and digit update; load beats clr beats step.
  always_comb begin
    state_nxt = state;
    presc_nxt = '0;
    tens_nxt  = tens;
    ones_nxt  = ones;
    carry_nxt = 1'b0;
    step_c    = 1'b0;

    if (ss_rise_c) begin
      state_nxt = (state == RUNNING) ? STOPPED : RUNNING;
    end

    // Prescaler only advances while running; a step fires on the wrap.
    if (state == RUNNING) begin
      if (presc == PMAX) begin
        step_c = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end

    if (load) begin
      tens_nxt  = sat9(load_val[7:4]);
      ones_nxt  = sat9(load_val[3:0]);
      presc_nxt = '0;
    end else if (clr) begin
      tens_nxt  = 4'd0;
      ones_nxt  = 4'd0;
      presc_nxt = '0;
    end else if (step_c) begin
      if (count_up_c) begin
        if (ones == 4'd9) begin
          ones_nxt = 4'd0;
          if (tens == 4'd9) begin
            tens_nxt  = 4'd0;
            carry_nxt = 1'b1;
          end else begin
            tens_nxt = tens + 4'd1;
          end
        end else begin
          ones_nxt = ones + 4'd1;
        end
      end else begin
        if (ones == 4'd0) begin
          ones_nxt = 4'd9;
          if (tens == 4'd0) begin
            tens_nxt  = 4'd9;
            carry_nxt = 1'b1;
          end else begin
            tens_nxt = tens - 4'd1;
          end
        end else begin
          ones_nxt = ones - 4'd1;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      tens  <= 4'd0;
      ones  <= 4'd0;
      carry <= 1'b0;
    end else begin
      presc <= presc_nxt;
      tens  <= tens_nxt;
      ones  <= ones_nxt;
      carry <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: directed self-checking bench for bcd_counter, PRESCALE=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bcd_counter;

  logic       clk;
  logic       reset;
  logic       start_stop;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
`ifdef BCD_COUNTER_DOWN_EN
  logic       dir;
`endif
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       carry;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_counter #(.PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
`ifdef BCD_COUNTER_DOWN_EN
    .dir        (dir),
`endif
    .tens       (tens),
    .ones       (ones),
    .running    (running),
    .carry      (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    clr        = 1'b0;
    load       = 1'b0;
    load_val   = 8'h00;
`ifdef BCD_COUNTER_DOWN_EN
    dir        = 1'b1;
`endif

    // Reset state
    tick(2);
    check("rst_digits",  {tens, ones}, 8'h00);
    check("rst_running", 8'(running),  8'h0);
    check("rst_carry",   8'(carry),    8'h0);
    reset = 1'b0;
    tick(1);

    // One-cycle start pulse, first step on the 4th edge after the toggle
    start_stop = 1'b1;
    tick(1);
    check("start_running", 8'(running), 8'h1);
    start_stop = 1'b0;
    tick(3);
    check("pre_step1", {tens, ones}, 8'h00);
    tick(1);
    check("step1", {tens, ones}, 8'h01);
    tick(3);
    check("pre_step2", {tens, ones}, 8'h01);
    tick(1);
    check("step2", {tens, ones}, 8'h02);
    check("no_carry", 8'(carry), 8'h0);

    // Load 98, run through the 99->00 wrap
    load_val = 8'h98;
    load     = 1'b1;
    tick(1);
    load = 1'b0;
    check("load98", {tens, ones}, 8'h98);
    tick(3);
    check("hold98", {tens, ones}, 8'h98);
    tick(1);
    check("to99", {tens, ones}, 8'h99);
    check("carry_at99", 8'(carry), 8'h0);
    tick(3);
    check("carry_pre_wrap", 8'(carry), 8'h0);
    tick(1);
    check("wrap00", {tens, ones}, 8'h00);
    check("carry_wrap", 8'(carry), 8'h1);
    tick(1);
    check("carry_one_cycle", 8'(carry), 8'h0);

    // Saturating load beats a coincident clear
    load_val = 8'hAF;
    load     = 1'b1;
    clr      = 1'b1;
    tick(1);
    load = 1'b0;
    clr  = 1'b0;
    check("load_sat_wins", {tens, ones}, 8'h99);
    check("load_no_carry", 8'(carry), 8'h0);

    // Clear alone keeps the run state
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_digits",  {tens, ones}, 8'h00);
    check("clr_running", 8'(running),  8'h1);
    check("clr_no_carry", 8'(carry),   8'h0);

    // Stop at 25 and hold
    load_val = 8'h24;
    load     = 1'b1;
    tick(1);
    load = 1'b0;
    check("load24", {tens, ones}, 8'h24);
    tick(4);
    check("to25", {tens, ones}, 8'h25);
    start_stop = 1'b1;
    tick(1);
    check("stop_running", 8'(running), 8'h0);
    start_stop = 1'b0;
    tick(20);
    check("hold25",       {tens, ones}, 8'h25);
    check("hold_running", 8'(running),  8'h0);

    // start_stop held high for 10 cycles toggles once
    start_stop = 1'b1;
    tick(1);
    check("restart_running", 8'(running), 8'h1);
    tick(9);
    check("held_one_toggle", 8'(running), 8'h1);
    check("held_count27", {tens, ones}, 8'h27);
    start_stop = 1'b0;

    // Asynchronous reset mid-count at 37
    load_val = 8'h37;
    load     = 1'b1;
    tick(1);
    load = 1'b0;
    check("load37", {tens, ones}, 8'h37);
    #3;
    reset = 1'b1;
    #1;
    check("async_digits",  {tens, ones}, 8'h00);
    check("async_running", 8'(running),  8'h0);
    check("async_carry",   8'(carry),    8'h0);

    // Level held high through reset is not an edge
    start_stop = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    check("held_thru_rst_running", 8'(running), 8'h0);
    start_stop = 1'b0;
    tick(8);
    check("idle_after_rst_digits",  {tens, ones}, 8'h00);
    check("idle_after_rst_running", 8'(running),  8'h0);

`ifdef BCD_COUNTER_DOWN_EN
    // Down count through the 00->99 wrap
    start_stop = 1'b1;
    tick(1);
    start_stop = 1'b0;
    check("down_running", 8'(running), 8'h1);
    dir      = 1'b0;
    load_val = 8'h01;
    load     = 1'b1;
    tick(1);
    load = 1'b0;
    check("down_load01", {tens, ones}, 8'h01);
    tick(4);
    check("down_to00", {tens, ones}, 8'h00);
    check("down_carry_00", 8'(carry), 8'h0);
    tick(4);
    check("down_wrap99", {tens, ones}, 8'h99);
    check("down_carry_wrap", 8'(carry), 8'h1);
    tick(1);
    check("down_carry_one_cycle", 8'(carry), 8'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
